net_packet_arbiter: RTL

Round-robin arbiter that shares the single `net_packet_s` network channel among `num_req_p` packet sources (host loader, debug injector, core-to-core forwarders). Each cycle it selects at most one valid requester, acknowledges it with a one-cycle `yumi`, and drives the chosen packet onto a registered output. When no packet is sent, the output carries a `NULL` op. The output feeds the core network input and the network packet logger.

---
 rtl/net_packet_arbiter_if.sv | 45 ++++
 rtl/net_packet_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/net_packet_arbiter_if.sv
// rtl/net_packet_arbiter_if.sv - network packet type and arbiter bus interface
// Requesters drive the master side; the arbiter owns the slave side.
package net_packet_pkg;

  typedef enum logic [1:0] {
    NULL  = 2'd0,
    INSTR = 2'd1,
    REG   = 2'd2,
    DATA  = 2'd3
  } net_op_e;

  typedef struct packed {
    net_op_e     net_op;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [31:0] data;
  } net_packet_s;

endpackage

interface net_packet_arbiter_if #(
  parameter int num_req_p = 4
) ();
  import net_packet_pkg::*;

  localparam int id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  net_packet_s [num_req_p-1:0] req_packet_i;
  logic [num_req_p-1:0]        req_valid_i;
  logic [num_req_p-1:0]        req_yumi_o;
  net_packet_s                 net_packet_o;
  logic [id_w_lp-1:0]          grant_id_o;
  logic [31:0]                 pkt_count_o;

  modport master (
    output req_packet_i, req_valid_i,
    input  req_yumi_o, net_packet_o, grant_id_o, pkt_count_o
  );

  modport slave (
    input  req_packet_i, req_valid_i,
    output req_yumi_o, net_packet_o, grant_id_o, pkt_count_o
  );

endinterface

// File: rtl/net_packet_arbiter.sv
// rtl/net_packet_arbiter.sv - round-robin arbiter onto the single network channel
// Optional burst lock (NET_ARB_BURST_LOCK_EN) keeps one requester granted up to max_burst_p cycles.
module net_packet_arbiter
  import net_packet_pkg::*;
#(
  parameter int num_req_p   = 4,
  parameter int max_burst_p = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  net_packet_arbiter_if.slave  bus
);

  localparam int id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  localparam net_packet_s null_pkt_lp = '{net_op: NULL, id: '0, addr: '0, data: '0};

  logic [id_w_lp-1:0] r_last;
  logic [id_w_lp-1:0] r_grant_id;
  net_packet_s        r_pkt;
  logic [31:0]        r_pkt_count;

  logic [id_w_lp-1:0] w_search;
  logic [id_w_lp-1:0] w_cand;
  logic [id_w_lp-1:0] w_sel;
  logic               w_found;
  logic               w_lock;
  logic               w_grant;

  // First valid requester strictly after the pointer, wrapping back to the pointer itself last.
  always_comb begin
    w_found  = 1'b0;
    w_search = r_last;
    w_cand   = r_last;
    for (int i = 1; i <= num_req_p; i++) begin
      w_cand = id_w_lp'((int'(r_last) + i) % num_req_p);
      if (!w_found && bus.req_valid_i[w_cand]) begin
        w_found  = 1'b1;
        w_search = w_cand;
      end
    end
  end

`ifdef NET_ARB_BURST_LOCK_EN
  logic [7:0] r_burst;
  logic       r_granted;

  assign w_lock = r_granted && bus.req_valid_i[r_last] &&
                  ((int'(r_burst) + 1) < max_burst_p);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_burst   <= '0;
      r_granted <= 1'b0;
    end else begin
      r_granted <= w_grant;
      r_burst   <= w_lock ? r_burst + 8'd1 : 8'd0;
    end
  end
`else
  assign w_lock = 1'b0;
  // max_burst_p has no effect in the pure round-robin build.
  if (max_burst_p < 1) begin : g_burst_unused
  end
`endif

  assign w_sel   = w_lock ? r_last : w_search;
  assign w_grant = reset && (w_lock || w_found);

  always_comb begin
    bus.req_yumi_o = '0;
    if (w_grant) begin
      bus.req_yumi_o[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last      <= id_w_lp'(num_req_p - 1);
      r_grant_id  <= '0;
      r_pkt       <= null_pkt_lp;
      r_pkt_count <= '0;
    end else if (w_grant) begin
      r_last     <= w_sel;
      r_grant_id <= w_sel;
      r_pkt      <= bus.req_packet_i[w_sel];
      // A granted NULL packet is still consumed but is not counted as traffic.
      if (bus.req_packet_i[w_sel].net_op != NULL) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end else begin
      r_pkt <= null_pkt_lp;
    end
  end

  assign bus.net_packet_o = r_pkt;
  assign bus.grant_id_o   = r_grant_id;
  assign bus.pkt_count_o  = r_pkt_count;

endmodule
